// File: rtl/ks_add_seq_pkg.sv
// Shared constants and FSM state type for the sequential Kogge-Stone adder.
package ks_pkg;

    localparam int SLICE_W    = 16;
    localparam int PASSES_MIN = 1;
    localparam int PASSES_MAX = 4;

    // Slice index is sized for the largest legal PASSES so every build shares one width.
    localparam int IDX_W = $clog2(PASSES_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/ks_add_seq_if.sv
// Operand/result handshake bundle for ks_add_seq; the ovf signal exists only when
// KS_SEQ_OVF_EN is defined.
interface ks_add_seq_if
    import ks_pkg::*;
#(
    parameter int W = 2 * SLICE_W
) ();

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef KS_SEQ_OVF_EN
    logic         ovf;
`endif

    modport master (
        output in_valid,
        output a,
        output b,
        output cin,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sum,
`ifdef KS_SEQ_OVF_EN
        input  ovf,
`endif
        input  cout
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  cin,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sum,
`ifdef KS_SEQ_OVF_EN
        output ovf,
`endif
        output cout
    );

endinterface

// File: rtl/ks_add_seq_ks.sv
// 16-bit Kogge-Stone adder without carry-in; the sequential wrapper adds the
// slice carry through a separate increment path.
module KS_top
    import ks_pkg::*;
(
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    output logic [SLICE_W-1:0] sum_o,
    output logic               cout_o
);

    localparam int LEVELS = $clog2(SLICE_W);

    // Parallel-prefix over all bits at once: after level l every bit holds the
    // group generate/propagate spanning 2^(l+1) bits down toward bit 0.
    always_comb begin : ksPrefix
        logic [SLICE_W-1:0] gen;
        logic [SLICE_W-1:0] prop;
        logic [SLICE_W-1:0] lowFill;
        gen   = a_i & b_i;
        prop  = a_i ^ b_i;
        for (int lvl = 0; lvl < LEVELS; lvl++) begin
            gen = gen | (prop & (gen << (1 << lvl)));
            if (lvl < LEVELS - 1) begin
                lowFill = (SLICE_W'(1) << (1 << lvl)) - SLICE_W'(1);
                prop    = prop & ((prop << (1 << lvl)) | lowFill);
            end
        end
        sum_o  = (a_i ^ b_i) ^ {gen[SLICE_W-2:0], 1'b0};
        cout_o = gen[SLICE_W-1];
    end

endmodule

// File: rtl/ks_add_seq.sv
// Multi-cycle W-bit adder: one 16-bit Kogge-Stone slice per cycle, valid/ready on
// both sides. Optional signed-overflow output enabled by KS_SEQ_OVF_EN.
module ks_add_seq
    import ks_pkg::*;
#(
    parameter int PASSES = 2
) (
    input logic         clk,
    input logic         rst,
    ks_add_seq_if.slave bus
);

    localparam int W = SLICE_W * PASSES;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PASSES - 1);

    if (PASSES < PASSES_MIN || PASSES > PASSES_MAX) begin : g_bad_passes
        $error("ks_add_seq: PASSES=%0d outside legal range %0d..%0d", PASSES, PASSES_MIN, PASSES_MAX);
    end

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   slice_q, slice_d;
    logic               carry_q, carry_d;
    logic [W-1:0]       opA_q, opA_d;
    logic [W-1:0]       opB_q, opB_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               cout_q, cout_d;
`ifdef KS_SEQ_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic [SLICE_W-1:0] ksA, ksB, ksSum, sliceSum;
    logic               ksCarry, sliceCarry;

    assign ksA = opA_q[slice_q*SLICE_W +: SLICE_W];
    assign ksB = opB_q[slice_q*SLICE_W +: SLICE_W];

    KS_top u_ks (
        .a_i    (ksA),
        .b_i    (ksB),
        .sum_o  (ksSum),
        .cout_o (ksCarry)
    );

    // A carry-in can only ripple out of the slice when the carry-free sum is all ones.
    assign sliceSum   = ksSum + SLICE_W'(carry_q);
    assign sliceCarry = ksCarry | (carry_q & (ksSum == '1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            slice_q <= '0;
            carry_q <= 1'b0;
            opA_q   <= '0;
            opB_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef KS_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            slice_q <= slice_d;
            carry_q <= carry_d;
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef KS_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        slice_d = slice_q;
        carry_d = carry_q;
        opA_d   = opA_q;
        opB_d   = opB_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef KS_SEQ_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    opA_d   = bus.a;
                    opB_d   = bus.b;
                    carry_d = bus.cin;
                    slice_d = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                sum_d[slice_q*SLICE_W +: SLICE_W] = sliceSum;
                carry_d = sliceCarry;
                slice_d = slice_q + 1'b1;
                if (slice_q == LAST_IDX) begin
                    slice_d = '0;
                    cout_d  = sliceCarry;
`ifdef KS_SEQ_OVF_EN
                    // Carry into the MSB is recovered from the MSB sum bit and operand bits.
                    ovf_d   = sliceSum[SLICE_W-1] ^ opA_q[W-1] ^ opB_q[W-1] ^ sliceCarry;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
`ifdef KS_SEQ_OVF_EN
    assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_ks_add_seq.sv
// Self-checking bench for ks_add_seq at PASSES=1, 2 and 4 against an arithmetic
// (A+B+cin) reference; ovf is checked when KS_SEQ_OVF_EN is defined.
module tb_ks_add_seq;

    localparam int BUDGET = 40;

    logic clk = 1'b0;
    logic rst1, rst2, rst4;
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    ks_add_seq_if #(.W(16)) if1 ();
    ks_add_seq_if #(.W(32)) if2 ();
    ks_add_seq_if #(.W(64)) if4 ();

    ks_add_seq #(.PASSES(1)) dut1 (.clk(clk), .rst(rst1), .bus(if1.slave));
    ks_add_seq #(.PASSES(2)) dut2 (.clk(clk), .rst(rst2), .bus(if2.slave));
    ks_add_seq #(.PASSES(4)) dut4 (.clk(clk), .rst(rst4), .bus(if4.slave));

    // Every comparison funnels through here so the summary counts stay honest.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic string tagOf(input int id, input string s);
        return $sformatf("d%0d.%s", id, s);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic driveIn(input int id, input logic v, input logic [63:0] a, input logic [63:0] b,
                           input logic c, input logic ordy);
        case (id)
            1: begin
                if1.in_valid = v; if1.a = a[15:0]; if1.b = b[15:0]; if1.cin = c; if1.out_ready = ordy;
            end
            2: begin
                if2.in_valid = v; if2.a = a[31:0]; if2.b = b[31:0]; if2.cin = c; if2.out_ready = ordy;
            end
            default: begin
                if4.in_valid = v; if4.a = a; if4.b = b; if4.cin = c; if4.out_ready = ordy;
            end
        endcase
    endtask

    task automatic driveJunk(input int id, input logic ordy);
        driveIn(id, 1'($urandom_range(0, 1)), {$urandom(), $urandom()}, {$urandom(), $urandom()},
                1'($urandom_range(0, 1)), ordy);
    endtask

    function automatic logic inReadyOf(input int id);
        case (id)
            1:       return if1.in_ready;
            2:       return if2.in_ready;
            default: return if4.in_ready;
        endcase
    endfunction

    function automatic logic outValidOf(input int id);
        case (id)
            1:       return if1.out_valid;
            2:       return if2.out_valid;
            default: return if4.out_valid;
        endcase
    endfunction

    function automatic logic [63:0] sumOf(input int id);
        case (id)
            1:       return {48'd0, if1.sum};
            2:       return {32'd0, if2.sum};
            default: return if4.sum;
        endcase
    endfunction

    function automatic logic coutOf(input int id);
        case (id)
            1:       return if1.cout;
            2:       return if2.cout;
            default: return if4.cout;
        endcase
    endfunction

`ifdef KS_SEQ_OVF_EN
    function automatic logic ovfOf(input int id);
        case (id)
            1:       return if1.ovf;
            2:       return if2.ovf;
            default: return if4.ovf;
        endcase
    endfunction
`endif

    function automatic logic [63:0] maskOf(input int w);
        return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [64:0] refAdd(input logic [63:0] a, input logic [63:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + 65'(c);
    endfunction

    // One full transaction: offer, accept, latency, hold with out_ready low, handshake.
    // Junk is driven on a/b/cin/in_valid after acceptance; none of it may leak into the result.
    task automatic applyStimulus(input int id, input int passes, input logic [63:0] a, input logic [63:0] b,
                                 input logic c, input int hold, input logic [63:0] expSum,
                                 input logic expCout, input logic expOvf);
        int waitCnt;
        int lat;
        driveIn(id, 1'b1, a, b, c, 1'b0);
        waitCnt = 0;
        while (!inReadyOf(id) && waitCnt < BUDGET) begin
            step();
            waitCnt++;
        end
        checkOutput(tagOf(id, "acceptReady"), 64'(inReadyOf(id)), 64'd1);
        step();
        lat = 0;
        while (!outValidOf(id) && lat < BUDGET) begin
            driveJunk(id, 1'($urandom_range(0, 1)));
            step();
            lat++;
        end
        checkOutput(tagOf(id, "latency"), 64'(lat), 64'(passes));
        for (int h = 0; h <= hold; h++) begin
            checkOutput(tagOf(id, "outValid"), 64'(outValidOf(id)), 64'd1);
            checkOutput(tagOf(id, "inReadyBusy"), 64'(inReadyOf(id)), 64'd0);
            checkOutput(tagOf(id, "sum"), sumOf(id), expSum);
            checkOutput(tagOf(id, "cout"), 64'(coutOf(id)), 64'(expCout));
`ifdef KS_SEQ_OVF_EN
            checkOutput(tagOf(id, "ovf"), 64'(ovfOf(id)), 64'(expOvf));
`endif
            driveJunk(id, (h == hold));
            step();
        end
        driveIn(id, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        checkOutput(tagOf(id, "postValid"), 64'(outValidOf(id)), 64'd0);
        checkOutput(tagOf(id, "postReady"), 64'(inReadyOf(id)), 64'd1);
    endtask

    task automatic randomRun(input int id, input int passes, input int n);
        int          w;
        logic [63:0] m, a, b, s;
        logic [64:0] full;
        logic        c, co, ov;
        w = 16 * passes;
        m = maskOf(w);
        for (int t = 0; t < n; t++) begin
            a = {$urandom(), $urandom()} & m;
            b = {$urandom(), $urandom()} & m;
            c = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       a = m;
                1:       b = m ^ a;
                default: ;
            endcase
            full = refAdd(a, b, c);
            s    = full[63:0] & m;
            co   = full[w];
            ov   = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
            repeat ($urandom_range(0, 2)) begin
                driveIn(id, 1'b0, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b0,
                        1'($urandom_range(0, 1)));
                step();
            end
            applyStimulus(id, passes, a, b, c, $urandom_range(0, 3), s, co, ov);
        end
    endtask

    task automatic checkResetState(input int id);
        checkOutput(tagOf(id, "rstSum"), sumOf(id), 64'd0);
        checkOutput(tagOf(id, "rstCout"), 64'(coutOf(id)), 64'd0);
        checkOutput(tagOf(id, "rstValid"), 64'(outValidOf(id)), 64'd0);
`ifdef KS_SEQ_OVF_EN
        checkOutput(tagOf(id, "rstOvf"), 64'(ovfOf(id)), 64'd0);
`endif
    endtask

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got time limit, expected bench completion");
        $fatal(1, "[TB] time limit reached");
    end

    initial begin
        rst1 = 1'b1;
        rst2 = 1'b1;
        rst4 = 1'b1;
        driveIn(1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        driveIn(2, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        driveIn(4, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        step();
        step();
        checkResetState(1);
        checkResetState(2);
        checkResetState(4);
        rst1 = 1'b0;
        rst2 = 1'b0;
        rst4 = 1'b0;
        step();
        checkOutput("d1.rstReady", 64'(inReadyOf(1)), 64'd1);
        checkOutput("d2.rstReady", 64'(inReadyOf(2)), 64'd1);
        checkOutput("d4.rstReady", 64'(inReadyOf(4)), 64'd1);

        $display("[TB] directed PASSES=2 cases");
        applyStimulus(2, 2, 64'h0000_FFFF, 64'h0000_0001, 1'b0, 0, 64'h0001_0000, 1'b0, 1'b0);
        applyStimulus(2, 2, 64'hFFFF_FFFF, 64'h0000_0000, 1'b1, 0, 64'h0000_0000, 1'b1, 1'b0);
        applyStimulus(2, 2, 64'h1234_5678, 64'h9ABC_DEF0, 1'b1, 5, 64'hACF1_3569, 1'b0, 1'b0);
        applyStimulus(2, 2, 64'h7FFF_FFFF, 64'h0000_0001, 1'b0, 1, 64'h8000_0000, 1'b0, 1'b1);
        applyStimulus(2, 2, 64'hFFFF_FFFF, 64'h0000_0001, 1'b0, 0, 64'h0000_0000, 1'b1, 1'b0);

        $display("[TB] reset abort during CALC");
        driveIn(2, 1'b1, 64'h0000_FFFF, 64'h0000_0001, 1'b0, 1'b1);
        step();
        driveIn(2, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
        rst2 = 1'b1;
        step();
        rst2 = 1'b0;
        checkOutput("d2.abortValid", 64'(outValidOf(2)), 64'd0);
        checkOutput("d2.abortReady", 64'(inReadyOf(2)), 64'd1);
        checkOutput("d2.abortSum", sumOf(2), 64'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            checkOutput("d2.noStale", 64'(outValidOf(2)), 64'd0);
        end
        applyStimulus(2, 2, 64'h0000_0003, 64'h0000_0004, 1'b1, 0, 64'h0000_0008, 1'b0, 1'b0);

        $display("[TB] directed PASSES=1 and PASSES=4 boundaries");
        applyStimulus(1, 1, 64'h0000_FFFF, 64'h0000_0001, 1'b0, 0, 64'h0000_0000, 1'b1, 1'b0);
        applyStimulus(1, 1, 64'h0000_7FFF, 64'h0000_0000, 1'b1, 2, 64'h0000_8000, 1'b0, 1'b1);
        applyStimulus(4, 4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 0, 64'd0, 1'b1, 1'b0);
        applyStimulus(4, 4, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1, 64'h8000_0000_0000_0000, 1'b0, 1'b1);

        $display("[TB] random runs");
        randomRun(1, 1, 1000);
        randomRun(4, 4, 1000);
        randomRun(2, 2, 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ks_add_seq.md
KS_ADD_SEQ -- requirements
Module: ks_add_seq

Interface
REQ-001 Parameter: PASSES, default 2, number of 16-bit slices per operand; legal range 1..4; W = 16*PASSES.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  operand set offered.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  W  operand A.
REQ-007 b  input  W  operand B.
REQ-008 cin  input  1  carry-in to slice 0.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 sum  output  W  (A+B+cin) mod 2^W.
REQ-012 cout  output  1  carry out of bit W-1.

Function
REQ-013 FSM states SHALL be IDLE, CALC, DONE; the reset state SHALL be IDLE.
REQ-014 IDLE: in_ready=1, out_valid=0; on in_valid, capture a, b and cin, set slice index k=0, carry register c=cin, and go to CALC.
REQ-015 CALC: one 16-bit slice per cycle; slice k result = a[16k+15:16k] + b[16k+15:16k] + c, written to sum[16k+15:16k]; c takes that slice's carry-out; k increments.
REQ-016 Slice add SHALL use the 16-bit Kogge-Stone adder (no carry-in) plus a carry-in increment: s = ks_sum + c (16-bit wrap); carry = ks_carry | (c & ks_sum==16'hFFFF).
REQ-017 After slice PASSES-1 completes, go to DONE with cout = final c.
REQ-018 Latency: out_valid SHALL rise exactly PASSES cycles after the accept edge.
REQ-019 DONE: out_valid=1, in_ready=0; sum, cout (and ovf) SHALL hold stable until out_valid & out_ready, then go to IDLE.
REQ-020 in_ready SHALL be 1 only in IDLE; minimum initiation interval = PASSES+2 cycles (next accept is no earlier than the cycle after the result handshake).
REQ-021 Changes on a, b or cin after acceptance SHALL have no effect on the in-flight result.
REQ-022 in_valid while in CALC or DONE SHALL be ignored; it is not lost if held until IDLE.
REQ-023 sum bits of slices not yet computed are don't-care while out_valid=0; consumers SHALL sample only at out_valid.

Reset
REQ-024 On rst: state=IDLE, k=0, c=0, sum=0, cout=0, ovf=0, out_valid=0; in_ready=1 on the first cycle after rst deasserts.
REQ-025 rst asserted in CALC or DONE SHALL abort the operation; no result is emitted for it.

Configuration
REQ-026 Macro KS_SEQ_OVF_EN defined: add output port ovf, 1 bit, registered at the DONE transition; ovf = signed overflow of the W-bit add (carry into bit W-1 XOR cout); it follows the same hold rules as sum.
REQ-027 Macro KS_SEQ_OVF_EN undefined: no ovf port and no overflow logic; all other behaviour is identical.

Structure
REQ-028 Shared package ks_pkg SHALL hold SLICE_W=16, the FSM state enum (IDLE, CALC, DONE) and the legal PASSES bounds.
REQ-029 One sub-module: the existing 16-bit Kogge-Stone adder KS_top, instantiated once and reused every CALC cycle; no other sub-modules.
REQ-030 Elaboration SHALL fail for PASSES outside 1..4.

Verification (PASSES=2 unless stated)
REQ-031 a=0x0000FFFF, b=0x00000001, cin=0 -> sum=0x00010000, cout=0; out_valid 2 cycles after accept.
REQ-032 a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1 (carry propagates across the slice boundary via the increment path).
REQ-033 Result held with out_ready=0 for 5 cycles -> sum, cout and out_valid are stable and in_ready=0 throughout; next accept is no earlier than the cycle after the handshake.
REQ-034 rst pulsed during the first CALC cycle -> the next cycle shows out_valid=0 and in_ready=1; no stale result appears afterwards.
REQ-035 With KS_SEQ_OVF_EN: a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, ovf=1, cout=0; a=0xFFFFFFFF, b=0x00000001 -> ovf=0, cout=1.
REQ-036 1000 random operand sets at PASSES=1 and PASSES=4, with random in_valid/out_ready gaps -> every result matches a behavioural (A+B+cin) model.
